lfsr_galois_checker: RTL

Receive-side checker for the 8-bit Galois LFSR pattern generator. It takes the generator's word stream, self-synchronises to it, and declares lock after a run of correct predictions. Once locked it flags mismatching words, counts them in a saturating counter, and drops lock after a run of consecutive errors. It sits at the far end of a link or loopback, paired with the generator, for BER-style testing.

---
 rtl/lfsr_galois_checker.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lfsr_galois_checker.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_galois_checker
// Purpose  : Receive-side checker for an 8-bit Galois LFSR word stream
//            (x^8+x^6+x^5+x^4+1). It self-synchronises to the stream, locks
//            after LOCK_CNT consecutive correct predictions, then flags and
//            counts mismatches. Lock drops after UNLOCK_CNT consecutive
//            mismatches.
// Ports    : clk          - system clock, rising edge
//            i_rst        - asynchronous reset, active low
//            i_soft_reset - synchronous clear, active high, wins over i_valid
//            i_valid      - i_lfsr carries a new word this cycle
//            i_lfsr[7:0]  - received LFSR word
//            o_lock       - high while locked
//            o_err        - one-cycle pulse for a mismatched word while locked
//            o_err_cnt    - saturating count of mismatches while locked
//            o_word_cnt   - saturating count of words compared while locked
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_galois_checker #(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_soft_reset,
  input  logic             i_valid,
  input  logic [7:0]       i_lfsr,
  output logic             o_lock,
  output logic             o_err,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [ERR_W-1:0] o_word_cnt
);

  localparam logic [3:0]       c_lock_cnt   = 4'(LOCK_CNT);
  localparam logic [3:0]       c_unlock_cnt = 4'(UNLOCK_CNT);
  localparam logic [ERR_W-1:0] c_cnt_max    = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] c_cnt_one    = {{(ERR_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t           r_state;
  logic [7:0]       r_ref;
  logic             r_ref_vld;
  logic [3:0]       r_good_run;
  logic [3:0]       r_bad_run;
  logic             r_lock;
  logic             r_err;
  logic [ERR_W-1:0] r_err_cnt;
  logic [ERR_W-1:0] r_word_cnt;

  logic [7:0]       w_exp;
  logic [3:0]       w_good_inc;
  logic [3:0]       w_bad_inc;

  // One Galois step: rotate left, then fold the feedback bit into taps 6..4.
  function automatic logic [7:0] f_step(input logic [7:0] s);
    logic       fb;
    logic [7:0] n;
    fb     = s[7];
    n      = {s[6:0], fb};
    n[6:4] = n[6:4] ^ {3{fb}};
    return n;
  endfunction

  assign w_exp      = f_step(r_ref);
  assign w_good_inc = r_good_run + 4'd1;
  assign w_bad_inc  = r_bad_run + 4'd1;

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= ST_UNLOCKED;
      r_ref      <= 8'h00;
      r_ref_vld  <= 1'b0;
      r_good_run <= 4'd0;
      r_bad_run  <= 4'd0;
      r_lock     <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (i_soft_reset) begin
      r_state    <= ST_UNLOCKED;
      r_ref      <= 8'h00;
      r_ref_vld  <= 1'b0;
      r_good_run <= 4'd0;
      r_bad_run  <= 4'd0;
      r_lock     <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_word_cnt <= '0;
    end else begin
      r_err <= 1'b0;
      if (i_valid) begin
        case (r_state)
          ST_UNLOCKED: begin
            // Always follow the received word so the checker resynchronises.
            r_ref <= i_lfsr;
            if (i_lfsr == 8'h00) begin
              // All-zero is the LFSR lock-up state; it can never seed a prediction.
              r_ref_vld  <= 1'b0;
              r_good_run <= 4'd0;
            end else if (!r_ref_vld) begin
              r_ref_vld <= 1'b1;
            end else if (i_lfsr == w_exp) begin
              if (w_good_inc == c_lock_cnt) begin
                r_state    <= ST_LOCKED;
                r_lock     <= 1'b1;
                r_bad_run  <= 4'd0;
                r_good_run <= 4'd0;
              end else begin
                r_good_run <= w_good_inc;
              end
            end else begin
              r_good_run <= 4'd0;
            end
          end

          ST_LOCKED: begin
            // Free-run the internal sequence so a corrupted word cannot
            // corrupt the next prediction.
            r_ref <= w_exp;
            if (r_word_cnt != c_cnt_max) begin
              r_word_cnt <= r_word_cnt + c_cnt_one;
            end
            if (i_lfsr == w_exp) begin
              r_bad_run <= 4'd0;
            end else begin
              r_err <= 1'b1;
              if (r_err_cnt != c_cnt_max) begin
                r_err_cnt <= r_err_cnt + c_cnt_one;
              end
              if (w_bad_inc == c_unlock_cnt) begin
                r_state    <= ST_UNLOCKED;
                r_lock     <= 1'b0;
                r_good_run <= 4'd0;
                r_bad_run  <= 4'd0;
                r_ref      <= i_lfsr;
                r_ref_vld  <= (i_lfsr != 8'h00);
              end else begin
                r_bad_run <= w_bad_inc;
              end
            end
          end

          default: begin
            r_state <= ST_UNLOCKED;
            r_lock  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_lock     = r_lock;
  assign o_err      = r_err;
  assign o_err_cnt  = r_err_cnt;
  assign o_word_cnt = r_word_cnt;

endmodule
`default_nettype wire
